irrigation_sec_timer: RTL

Units-of-seconds countdown stage and run controller for the irrigation timer. It divides the system clock down to a 1 s tick and counts the units digit down in BCD. It presets and borrows from the downstream 2-bit tens-of-seconds digit, which counts down and is enabled by this block's `tens_tick`. The valve is driven for exactly `10*tens + units` ticks after a start request.

---
 rtl/irrigation_sec_timer.sv | 110 +++++++++++
 1 files changed

// File: rtl/irrigation_sec_timer.sv
// Units-of-seconds BCD countdown and valve run controller.
// Borrows from an external 2-bit tens digit via tens_tick/set/clr.
module irrigation_sec_timer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] load_units,
  input  logic [1:0] load_tens,
  input  logic       tens_zero,
  output logic       tens_tick,
  output logic [1:0] tens_set,
  output logic [1:0] tens_clr,
  output logic [3:0] units,
  output logic       valve,
  output logic       busy,
  output logic       done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ABORT = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] presc;
  logic [1:0]    tens_lat;
  logic          tick;

  assign tick = (presc == LAST);

  // Outputs are registered decodes of the state being left,
  // so they trail the state register by one cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      presc     <= '0;
      tens_lat  <= 2'b00;
      units     <= 4'd0;
      valve     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tens_tick <= 1'b0;
      tens_set  <= 2'b00;
      tens_clr  <= 2'b00;
    end else begin
      tens_tick <= 1'b0;
      tens_set  <= 2'b00;
      tens_clr  <= 2'b00;
      valve     <= (state == RUN) && !abort;
      busy      <= (state != IDLE);
      done      <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            units    <= (load_units > 4'd9) ? 4'd9 : load_units;
            tens_lat <= load_tens;
            state    <= LOAD;
          end
        end
        LOAD: begin
          tens_set <= tens_lat;
          tens_clr <= ~tens_lat;
          presc    <= '0;
          if (units == 4'd0 && tens_lat == 2'b00)
            state <= DONE;
          else
            state <= RUN;
        end
        RUN: begin
          // Abort beats a coincident tick; the tick is dropped.
          if (abort) begin
            state <= ABORT;
          end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
              if (units == 4'd1 && tens_zero) begin
                units <= 4'd0;
                state <= DONE;
              end else if (units == 4'd0) begin
                units     <= 4'd9;
                tens_tick <= 1'b1;
              end else begin
                units <= units - 4'd1;
              end
            end
          end
        end
        ABORT: begin
          tens_clr <= 2'b11;
          units    <= 4'd0;
          state    <= IDLE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
